// File: rtl/adc_model_pkg.sv
// adc_model_pkg: shared types and constants for the SPI A2D converter model
package adc_model_pkg;
   typedef enum logic {PAIRED, PIPELINED} mode_t;
   typedef enum logic {FIRST, SECOND} state_t;
   localparam int FRAME_BITS = 16;
   localparam int CH_LSB = 11;
endpackage

// File: rtl/spi_slave_frame16.sv
// spi_slave_frame16: mode-0 SPI slave front end that frames 16-bit words in the clk domain
module spi_slave_frame16
   import adc_model_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic [15:0] tx_word,
   output logic        MISO,
   output logic [15:0] cmd,
   output logic        frame_done,
   output logic        frame_abort
);
   logic [2:0]  ss_sr;
   logic [2:0]  sck_sr;
   logic [1:0]  mosi_sr;
   logic [1:0]  vld;
   logic        armed;
   logic        act;
   logic [4:0]  cnt;
   logic [15:0] rx;
   logic [15:0] tx;
   logic        ss_fall;
   logic        ss_rise;
   logic        sck_rise;
   logic        sck_fall;
   logic        start;

   assign ss_fall  = ss_sr[2] & ~ss_sr[1];
   assign ss_rise  = ~ss_sr[2] & ss_sr[1];
   assign sck_rise = ~sck_sr[2] & sck_sr[1];
   assign sck_fall = sck_sr[2] & ~sck_sr[1];
   assign start    = ss_fall & armed;

   // double-flop the SPI pins; the third stage only serves edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sr   <= 3'b111;
         sck_sr  <= 3'b000;
         mosi_sr <= 2'b00;
         vld     <= 2'b00;
      end else begin
         ss_sr   <= {ss_sr[1:0], SS_n};
         sck_sr  <= {sck_sr[1:0], SCLK};
         mosi_sr <= {mosi_sr[0], MOSI};
         vld     <= {vld[0], 1'b1};
      end
   end

   // after reset, accept frames only once a genuinely high SS_n has been seen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else armed <= armed | (vld[1] & ss_sr[1]);
   end

   // frame tracking, receive/transmit shifting and SCLK rise counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act <= 1'b0;
         cnt <= '0;
         rx  <= '0;
         tx  <= '0;
      end else if (start) begin
         act <= 1'b1;
         cnt <= '0;
         tx  <= tx_word;
      end else if (ss_rise) begin
         act <= 1'b0;
      end else if (act) begin
         if (sck_rise) begin
            rx  <= {rx[14:0], mosi_sr[1]};
            cnt <= cnt + {4'd0, cnt != 5'd31};
         end
         if (sck_fall) tx <= {tx[14:0], 1'b0};
      end
   end

   assign frame_done  = ss_rise & act & (cnt == 5'(FRAME_BITS));
   assign frame_abort = ss_rise & act & (cnt != 5'(FRAME_BITS));
   assign cmd         = rx;
   assign MISO        = act ? tx[15] : 1'bz;
endmodule

// File: rtl/adc_spi_model_multi.sv
// adc_spi_model_multi: parametrised multi-channel SPI A2D converter model
module adc_spi_model_multi
   import adc_model_pkg::*;
#(
   parameter int          NUM_CH     = 8,
   parameter int          RES        = 12,
   parameter logic [15:0] VALID_MASK = 16'h0071,
   parameter int          MODE       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  SS_n,
   input  logic                  SCLK,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [NUM_CH*RES-1:0] chan_val,
   output logic                  err_inval,
   output logic                  err_frame,
   output logic [7:0]            frame_cnt
);
   localparam int    CW = $clog2(NUM_CH);
   localparam mode_t M  = (MODE == 1) ? PIPELINED : PAIRED;

   state_t          state;
   state_t          state_nxt;
   logic [15:0]     cmd;
   logic [15:0]     tx_word;
   logic            frame_done;
   logic            frame_abort;
   logic [CW-1:0]   fld;
   logic [CW-1:0]   ch;
   logic [RES-1:0]  value;
   logic [RES-1:0]  sel;
   logic            inv;
   logic            upd;
   logic            unused_bits;

   spi_slave_frame16 u_spi (
      .clk         (clk),
      .rst_n       (rst_n),
      .SS_n        (SS_n),
      .SCLK        (SCLK),
      .MOSI        (MOSI),
      .tx_word     (tx_word),
      .MISO        (MISO),
      .cmd         (cmd),
      .frame_done  (frame_done),
      .frame_abort (frame_abort)
   );

   assign fld         = cmd[CH_LSB +: CW];
   assign inv         = (int'(fld) >= NUM_CH) || !VALID_MASK[4'(fld)];
   assign tx_word     = {{(16 - RES){1'b0}}, value};
   assign unused_bits = ^{cmd, ch};

   // pick the analog value addressed by the channel field
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_CH; i++) if (fld == CW'(i)) sel = chan_val[i*RES +: RES];
   end

   // transaction state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FIRST;
      else state <= state_nxt;
   end

   // paired mode alternates command/data frames; pipelined mode updates on every frame
   always_comb begin
      state_nxt = state;
      upd       = 1'b0;
      if (frame_done) begin
         upd       = (M == PIPELINED) || (state == FIRST);
         state_nxt = (M == PIPELINED || state == SECOND) ? FIRST : SECOND;
      end
   end

   // channel/value capture, sticky errors and completed-frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch        <= '0;
         value     <= '0;
         err_inval <= 1'b0;
         err_frame <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         if (upd) begin
            ch    <= fld;
            value <= inv ? '0 : sel;
         end
         if (upd && inv) err_inval <= 1'b1;
         if (frame_abort) err_frame <= 1'b1;
         if (frame_done) frame_cnt <= frame_cnt + 8'd1;
      end
   end

`ifndef SYNTHESIS
   // one warning per invalid channel command
   always @(posedge clk) begin
      if (rst_n && upd && inv) $display("adc_spi_model_multi: warning, invalid channel %0d commanded", fld);
   end
`endif
endmodule

// File: tb/tb_adc_spi_model_multi.sv
// tb_adc_spi_model_multi: directed checks of the A2D model in paired, pipelined, 6-channel and 10-bit builds
module tb_adc_spi_model_multi;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        SCLK = 1'b0;
   logic        MOSI = 1'b0;
   logic [3:0]  ss = 4'hF;
   logic [3:0]  miso;
   logic [3:0]  ei;
   logic [3:0]  ef;
   logic [7:0]  fc [4];
   logic [95:0] cv = '0;
   logic [71:0] cv6 = '0;
   logic [79:0] cv10 = '0;
   logic [15:0] r;
   int          n_run = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   adc_spi_model_multi u0 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss[0]), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso[0]),
      .chan_val(cv), .err_inval(ei[0]), .err_frame(ef[0]), .frame_cnt(fc[0])
   );

   adc_spi_model_multi #(.MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss[1]), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso[1]),
      .chan_val(cv), .err_inval(ei[1]), .err_frame(ef[1]), .frame_cnt(fc[1])
   );

   adc_spi_model_multi #(.NUM_CH(6), .VALID_MASK(16'hFFFF)) u2 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss[2]), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso[2]),
      .chan_val(cv6), .err_inval(ei[2]), .err_frame(ef[2]), .frame_cnt(fc[2])
   );

   adc_spi_model_multi #(.RES(10), .MODE(1)) u3 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss[3]), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso[3]),
      .chan_val(cv10), .err_inval(ei[3]), .err_frame(ef[3]), .frame_cnt(fc[3])
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic clock_bits(input int d, input logic [15:0] c, input int n, output logic [15:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         MOSI = c[15-i];
         #50;
         rx = {rx[14:0], miso[d]};
         SCLK = 1'b1;
         #50;
         SCLK = 1'b0;
      end
   endtask

   task automatic frame(input int d, input logic [15:0] c, input int n, output logic [15:0] rx);
      ss[d] = 1'b0;
      #80;
      clock_bits(d, c, n, rx);
      #50;
      ss[d] = 1'b1;
      #100;
   endtask

   initial begin
      cv[0 +: 12]    = 12'hC00;
      cv[24 +: 12]   = 12'h777;
      cv[48 +: 12]   = 12'h5A5;
      cv[60 +: 12]   = 12'h123;
      cv6[0 +: 12]   = 12'hABC;
      cv6[60 +: 12]  = 12'h321;
      cv10[0 +: 10]  = 10'h100;
      cv10[50 +: 10] = 10'h3FF;
      #23;
      chk("rst_frame_cnt", {8'd0, fc[0]}, 16'h0000);
      chk("rst_err_inval", {15'd0, ei[0]}, 16'h0000);
      chk("rst_err_frame", {15'd0, ef[0]}, 16'h0000);
      rst_n = 1'b1;
      #50;
      frame(0, 16'h2000, 16, r); chk("p_f1", r, 16'h0000);
      frame(0, 16'h0000, 16, r); chk("p_f2_ch4", r, 16'h05A5);
      frame(0, 16'h0000, 16, r); chk("p_f3", r, 16'h05A5);
      frame(0, 16'h2000, 16, r); chk("p_f4_ch0", r, 16'h0C00);
      chk("p_cnt4", {8'd0, fc[0]}, 16'h0004);
      chk("p_inval0", {15'd0, ei[0]}, 16'h0000);
      frame(0, 16'h1000, 16, r); chk("p_f5", r, 16'h0C00);
      chk("p_inval1", {15'd0, ei[0]}, 16'h0001);
      frame(0, 16'h0000, 16, r); chk("p_f6_inv", r, 16'h0000);
      frame(0, 16'h2000, 9, r);
      chk("p_abort_err", {15'd0, ef[0]}, 16'h0001);
      chk("p_abort_cnt", {8'd0, fc[0]}, 16'h0006);
      frame(0, 16'h2800, 16, r); chk("p_f7", r, 16'h0000);
      frame(0, 16'h0000, 16, r); chk("p_f8_ch5", r, 16'h0123);
      chk("p_cnt8", {8'd0, fc[0]}, 16'h0008);
      frame(1, 16'h0000, 16, r); chk("q_f1", r, 16'h0000);
      frame(1, 16'h2000, 16, r); chk("q_f2", r, 16'h0C00);
      frame(1, 16'h2800, 16, r); chk("q_f3", r, 16'h05A5);
      frame(1, 16'h0000, 16, r); chk("q_f4", r, 16'h0123);
      chk("q_cnt4", {8'd0, fc[1]}, 16'h0004);
      frame(2, 16'h0000, 16, r); chk("n6_f1", r, 16'h0000);
      frame(2, 16'h2800, 16, r); chk("n6_f2", r, 16'h0ABC);
      chk("n6_inval0", {15'd0, ei[2]}, 16'h0000);
      frame(2, 16'h3000, 16, r); chk("n6_f3", r, 16'h0ABC);
      frame(2, 16'h0000, 16, r); chk("n6_f4_range", r, 16'h0000);
      chk("n6_inval1", {15'd0, ei[2]}, 16'h0001);
      frame(2, 16'h2800, 16, r); chk("n6_f5", r, 16'h0000);
      frame(2, 16'h0000, 16, r); chk("n6_f6_ch5", r, 16'h0321);
      chk("n6_sticky", {15'd0, ei[2]}, 16'h0001);
      frame(3, 16'h2800, 16, r); chk("r10_f1", r, 16'h0000);
      fork
         frame(3, 16'h0000, 16, r);
         begin
            #400;
            cv10[50 +: 10] = 10'h155;
         end
      join
      chk("r10_f2_inflight", r, 16'h03FF);
      frame(3, 16'h2800, 16, r); chk("r10_f3", r, 16'h0100);
      frame(3, 16'h0000, 16, r); chk("r10_f4", r, 16'h0155);
      ss[0] = 1'b0;
      #80;
      clock_bits(0, 16'hFFFF, 7, r);
      rst_n = 1'b0;
      #50;
      chk("mr_cnt", {8'd0, fc[0]}, 16'h0000);
      chk("mr_err_inval", {15'd0, ei[0]}, 16'h0000);
      chk("mr_err_frame", {15'd0, ef[0]}, 16'h0000);
      chk("mr_cnt_q", {8'd0, fc[1]}, 16'h0000);
      rst_n = 1'b1;
      #50;
      clock_bits(0, 16'h2000, 16, r);
      #50;
      ss[0] = 1'b1;
      #100;
      chk("mr_ignored_cnt", {8'd0, fc[0]}, 16'h0000);
      chk("mr_ignored_err", {15'd0, ef[0]}, 16'h0000);
      frame(0, 16'h2000, 16, r); chk("mr_f1", r, 16'h0000);
      chk("mr_cnt1", {8'd0, fc[0]}, 16'h0001);
      frame(0, 16'h0000, 16, r); chk("mr_f2_ch4", r, 16'h05A5);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
